// File: rtl/rom_sweep_sequencer.sv
// rom_sweep_sequencer
// Sequential front-end for the ROM/mux/ALU/adder datapath. Walks rom1 over a
// programmed address range (modulo 32, inclusive of both ends), holds the
// rom2..rom6 selects fixed for the sweep, waits SETTLE cycles per address,
// captures the datapath result and hands it downstream over valid/ready.
module rom_sweep_sequencer #(
    parameter int SIZE   = 32,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [4:0]      cfg_first,
    input  logic [4:0]      cfg_last,
    input  logic [1:0]      cfg_rom2,
    input  logic [1:0]      cfg_rom3,
    input  logic [1:0]      cfg_rom4,
    input  logic [1:0]      cfg_rom5,
    input  logic [2:0]      cfg_rom6,
    output logic [4:0]      rom1_in,
    output logic [1:0]      rom2_in,
    output logic [1:0]      rom3_in,
    output logic [1:0]      rom4_in,
    output logic [1:0]      rom5_in,
    output logic [2:0]      rom6_in,
    input  logic [SIZE-1:0] result_in,
    output logic [SIZE-1:0] out_data,
    output logic [4:0]      out_index,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Counter value on the edge that completes the settle interval.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t          state_r, state_s;
    logic [4:0]      rom1_r, rom1_s;
    logic [1:0]      rom2_r, rom2_s;
    logic [1:0]      rom3_r, rom3_s;
    logic [1:0]      rom4_r, rom4_s;
    logic [1:0]      rom5_r, rom5_s;
    logic [2:0]      rom6_r, rom6_s;
    logic [4:0]      last_r, last_s;
    logic [3:0]      cnt_r, cnt_s;
    logic [SIZE-1:0] data_r, data_s;
    logic [4:0]      index_r, index_s;
    logic            valid_r, valid_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_s = state_r;
        rom1_s  = rom1_r;
        rom2_s  = rom2_r;
        rom3_s  = rom3_r;
        rom4_s  = rom4_r;
        rom5_s  = rom5_r;
        rom6_s  = rom6_r;
        last_s  = last_r;
        cnt_s   = cnt_r;
        data_s  = data_r;
        index_s = index_r;
        valid_s = valid_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    rom1_s  = cfg_first;
                    rom2_s  = cfg_rom2;
                    rom3_s  = cfg_rom3;
                    rom4_s  = cfg_rom4;
                    rom5_s  = cfg_rom5;
                    rom6_s  = cfg_rom6;
                    last_s  = cfg_last;
                    busy_s  = 1'b1;
                    cnt_s   = 4'd0;
                    state_s = DRIVE;
                end else begin
                    state_s = IDLE;
                end
            end
            DRIVE: begin
                cnt_s = cnt_r + 4'd1;
                if (cnt_r == SETTLE_LAST) begin
                    data_s  = result_in;
                    index_s = rom1_r;
                    valid_s = 1'b1;
                    state_s = HOLD;
                end else begin
                    state_s = DRIVE;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    valid_s = 1'b0;
                    if (rom1_r == last_r) begin
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        state_s = IDLE;
                    end else begin
                        rom1_s  = rom1_r + 5'd1;
                        cnt_s   = 4'd0;
                        state_s = DRIVE;
                    end
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                valid_s = 1'b0;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            rom1_r  <= 5'd0;
            rom2_r  <= 2'd0;
            rom3_r  <= 2'd0;
            rom4_r  <= 2'd0;
            rom5_r  <= 2'd0;
            rom6_r  <= 3'd0;
            last_r  <= 5'd0;
            cnt_r   <= 4'd0;
            data_r  <= '0;
            index_r <= 5'd0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            rom1_r  <= rom1_s;
            rom2_r  <= rom2_s;
            rom3_r  <= rom3_s;
            rom4_r  <= rom4_s;
            rom5_r  <= rom5_s;
            rom6_r  <= rom6_s;
            last_r  <= last_s;
            cnt_r   <= cnt_s;
            data_r  <= data_s;
            index_r <= index_s;
            valid_r <= valid_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign rom1_in   = rom1_r;
    assign rom2_in   = rom2_r;
    assign rom3_in   = rom3_r;
    assign rom4_in   = rom4_r;
    assign rom5_in   = rom5_r;
    assign rom6_in   = rom6_r;
    assign out_data  = data_r;
    assign out_index = index_r;
    assign out_valid = valid_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_rom_sweep_sequencer.sv
// Testbench for rom_sweep_sequencer: a SETTLE=1 instance exercised with
// directed and randomized sweeps against an arithmetic model of the expected
// element list, plus a SETTLE=3 instance for the single-element latency case.
module tb_rom_sweep_sequencer;

    localparam int SETTLE_A = 1;
    localparam int SETTLE_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A signals
    logic        a_rst_n, a_start, a_out_ready;
    logic [4:0]  a_cfg_first, a_cfg_last;
    logic [1:0]  a_cfg_rom2, a_cfg_rom3, a_cfg_rom4, a_cfg_rom5;
    logic [2:0]  a_cfg_rom6;
    logic [4:0]  a_rom1;
    logic [1:0]  a_rom2, a_rom3, a_rom4, a_rom5;
    logic [2:0]  a_rom6;
    logic [31:0] a_result, a_out_data;
    logic [4:0]  a_out_index;
    logic        a_out_valid, a_busy, a_done;

    // Instance B signals
    logic        b_rst_n, b_start, b_out_ready;
    logic [4:0]  b_cfg_first, b_cfg_last;
    logic [1:0]  b_cfg_rom2, b_cfg_rom3, b_cfg_rom4, b_cfg_rom5;
    logic [2:0]  b_cfg_rom6;
    logic [4:0]  b_rom1;
    logic [1:0]  b_rom2, b_rom3, b_rom4, b_rom5;
    logic [2:0]  b_rom6;
    logic [31:0] b_result, b_out_data;
    logic [4:0]  b_out_index;
    logic        b_out_valid, b_busy, b_done;

    // Datapath stand-in: result = {rom1, 4'h0} + rom6
    assign a_result = {23'd0, a_rom1, 4'h0} + {29'd0, a_rom6};
    assign b_result = {23'd0, b_rom1, 4'h0} + {29'd0, b_rom6};

    rom_sweep_sequencer #(.SIZE(32), .SETTLE(SETTLE_A)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .start(a_start),
        .cfg_first(a_cfg_first), .cfg_last(a_cfg_last),
        .cfg_rom2(a_cfg_rom2), .cfg_rom3(a_cfg_rom3), .cfg_rom4(a_cfg_rom4),
        .cfg_rom5(a_cfg_rom5), .cfg_rom6(a_cfg_rom6),
        .rom1_in(a_rom1), .rom2_in(a_rom2), .rom3_in(a_rom3),
        .rom4_in(a_rom4), .rom5_in(a_rom5), .rom6_in(a_rom6),
        .result_in(a_result), .out_data(a_out_data), .out_index(a_out_index),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .busy(a_busy), .done(a_done)
    );

    rom_sweep_sequencer #(.SIZE(32), .SETTLE(SETTLE_B)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .start(b_start),
        .cfg_first(b_cfg_first), .cfg_last(b_cfg_last),
        .cfg_rom2(b_cfg_rom2), .cfg_rom3(b_cfg_rom3), .cfg_rom4(b_cfg_rom4),
        .cfg_rom5(b_cfg_rom5), .cfg_rom6(b_cfg_rom6),
        .rom1_in(b_rom1), .rom2_in(b_rom2), .rom3_in(b_rom3),
        .rom4_in(b_rom4), .rom5_in(b_rom5), .rom6_in(b_rom6),
        .result_in(b_result), .out_data(b_out_data), .out_index(b_out_index),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .busy(b_busy), .done(b_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_valid"}, 32'(a_out_valid), 32'd0);
        check({tag, "_done"},  32'(a_done),      32'd0);
        check({tag, "_busy"},  32'(a_busy),      32'd0);
        check({tag, "_rom1"},  32'(a_rom1),      32'd0);
        check({tag, "_sel"},   32'({a_rom2, a_rom3, a_rom4, a_rom5, a_rom6}), 32'd0);
        check({tag, "_data"},  a_out_data,       32'd0);
        check({tag, "_index"}, 32'(a_out_index), 32'd0);
    endtask

    // Run one sweep on instance A; expected element k has index (f+k) mod 32
    // and data index*16 + rom6.
    task automatic sweep_a(input logic [4:0] f, input logic [4:0] l,
                           input logic [1:0] r2, input logic [1:0] r3,
                           input logic [1:0] r4, input logic [1:0] r5,
                           input logic [2:0] r6, input int ready_pct,
                           input bit stall_first, input bit disturb);
        logic [4:0]  span;
        logic [10:0] sel_exp;
        int count, k, steps, stall, exp_idx;
        bit finished;
        span     = l - f;
        count    = int'(span) + 1;
        sel_exp  = {r2, r3, r4, r5, r6};
        k        = 0;
        steps    = 0;
        stall    = 0;
        finished = 1'b0;
        a_cfg_first = f;  a_cfg_last = l;
        a_cfg_rom2 = r2;  a_cfg_rom3 = r3; a_cfg_rom4 = r4;
        a_cfg_rom5 = r5;  a_cfg_rom6 = r6;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        check("start_busy", 32'(a_busy), 32'd1);
        check("start_rom1", 32'(a_rom1), 32'(f));
        for (int cyc = 0; cyc < 1000 && !finished; cyc++) begin
            exp_idx = (int'(f) + k) % 32;
            if (disturb && cyc == 1) begin
                a_start = 1'b1;
                a_cfg_first = ~f;  a_cfg_last = ~l;
                a_cfg_rom2 = ~r2;  a_cfg_rom3 = ~r3; a_cfg_rom4 = ~r4;
                a_cfg_rom5 = ~r5;  a_cfg_rom6 = ~r6;
            end else begin
                a_start = 1'b0;
            end
            check("sel_hold", 32'({a_rom2, a_rom3, a_rom4, a_rom5, a_rom6}), 32'(sel_exp));
            check("busy_during", 32'(a_busy), 32'd1);
            check("addr", 32'(a_rom1), 32'(exp_idx));
            if (a_out_valid) begin
                check("valid_no_done", 32'(a_done), 32'd0);
                check("out_index", 32'(a_out_index), 32'(exp_idx));
                check("out_data", a_out_data, 32'(exp_idx * 16 + int'(r6)));
                if (stall_first && k == 0 && stall < 4) begin
                    a_out_ready = 1'b0;
                    stall++;
                end else begin
                    a_out_ready = ($urandom_range(99) < 32'(ready_pct));
                end
                if (a_out_ready) k++;
            end else begin
                check("no_done_mid", 32'(a_done), 32'd0);
                a_out_ready = ($urandom_range(99) < 32'(ready_pct));
            end
            step();
            steps++;
            if (k == count) begin
                check("done_pulse", 32'(a_done), 32'd1);
                check("done_busy", 32'(a_busy), 32'd0);
                check("done_valid", 32'(a_out_valid), 32'd0);
                if (ready_pct == 100 && !stall_first)
                    check("throughput", 32'(steps), 32'(count * (SETTLE_A + 1)));
                a_start = 1'b0;
                a_out_ready = 1'b0;
                step();
                check("done_once", 32'(a_done), 32'd0);
                check("idle_valid", 32'(a_out_valid), 32'd0);
                finished = 1'b1;
            end
        end
        check("sweep_finished", 32'(finished), 32'd1);
    endtask

    initial begin
        bit got;
        a_rst_n = 1'b0; a_start = 1'b0; a_out_ready = 1'b0;
        a_cfg_first = 5'd0; a_cfg_last = 5'd0;
        a_cfg_rom2 = 2'd0; a_cfg_rom3 = 2'd0; a_cfg_rom4 = 2'd0;
        a_cfg_rom5 = 2'd0; a_cfg_rom6 = 3'd0;
        b_rst_n = 1'b0; b_start = 1'b0; b_out_ready = 1'b0;
        b_cfg_first = 5'd0; b_cfg_last = 5'd0;
        b_cfg_rom2 = 2'd0; b_cfg_rom3 = 2'd0; b_cfg_rom4 = 2'd0;
        b_cfg_rom5 = 2'd0; b_cfg_rom6 = 3'd0;
        step();
        step();
        check_a_zero("reset");
        check("reset_b_valid", 32'(b_out_valid), 32'd0);
        check("reset_b_busy", 32'(b_busy), 32'd0);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        step();
        check_a_zero("idle");

        // Basic sweep 3..5 and wrap-around sweep 30..1
        sweep_a(5'd3, 5'd5, 2'd0, 2'd0, 2'd0, 2'd0, 3'd2, 100, 1'b0, 1'b0);
        sweep_a(5'd30, 5'd1, 2'd0, 2'd0, 2'd0, 2'd0, 3'd2, 100, 1'b0, 1'b0);
        // Backpressure: ready low for 4 cycles on the first element
        sweep_a(5'd10, 5'd12, 2'd1, 2'd2, 2'd3, 2'd1, 3'd5, 100, 1'b1, 1'b0);
        // Start and cfg changes mid-sweep are ignored; the next start uses them
        sweep_a(5'd4, 5'd6, 2'd1, 2'd1, 2'd2, 2'd3, 3'd7, 100, 1'b0, 1'b1);
        sweep_a(5'd27, 5'd25, 2'd2, 2'd2, 2'd1, 2'd0, 3'd0, 80, 1'b0, 1'b0);
        // Single element
        sweep_a(5'd17, 5'd17, 2'd3, 2'd0, 2'd1, 2'd2, 3'd4, 100, 1'b0, 1'b0);

        // Reset while holding a result
        a_cfg_first = 5'd0; a_cfg_last = 5'd7;
        a_cfg_rom2 = 2'd3; a_cfg_rom3 = 2'd3; a_cfg_rom4 = 2'd3;
        a_cfg_rom5 = 2'd3; a_cfg_rom6 = 3'd6;
        a_out_ready = 1'b0;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (a_out_valid) got = 1'b1;
            else step();
        end
        check("hold_reached", 32'(got), 32'd1);
        a_rst_n = 1'b0;
        step();
        check_a_zero("abort");
        a_rst_n = 1'b1;
        step();
        check_a_zero("post_abort");
        sweep_a(5'd0, 5'd7, 2'd3, 2'd3, 2'd3, 2'd3, 3'd6, 100, 1'b0, 1'b0);

        // Randomized sweeps
        for (int n = 0; n < 6; n++) begin
            sweep_a(5'($urandom_range(31)), 5'($urandom_range(31)),
                    2'($urandom_range(3)), 2'($urandom_range(3)),
                    2'($urandom_range(3)), 2'($urandom_range(3)),
                    3'($urandom_range(7)), int'($urandom_range(100, 30)),
                    1'b0, 1'b0);
        end

        // SETTLE=3 instance, single element at address 9
        b_cfg_first = 5'd9; b_cfg_last = 5'd9; b_cfg_rom6 = 3'd2;
        b_out_ready = 1'b1;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        check("b_e0_valid", 32'(b_out_valid), 32'd0);
        check("b_e0_rom1", 32'(b_rom1), 32'd9);
        step();
        check("b_e1_valid", 32'(b_out_valid), 32'd0);
        step();
        check("b_e2_valid", 32'(b_out_valid), 32'd0);
        step();
        check("b_e3_valid", 32'(b_out_valid), 32'd1);
        check("b_e3_data", b_out_data, 32'h092);
        check("b_e3_index", 32'(b_out_index), 32'd9);
        check("b_e3_busy", 32'(b_busy), 32'd1);
        check("b_e3_done", 32'(b_done), 32'd0);
        check("b_e3_sel", 32'({b_rom2, b_rom3, b_rom4, b_rom5, b_rom6}), 32'd2);
        step();
        check("b_done_pulse", 32'(b_done), 32'd1);
        check("b_done_busy", 32'(b_busy), 32'd0);
        check("b_done_valid", 32'(b_out_valid), 32'd0);
        step();
        check("b_done_once", 32'(b_done), 32'd0);
        check("b_idle_valid", 32'(b_out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
